// File: rtl/pfb_frame_packer.sv
// Pairs the 2-branch filter stream into {B,A} words, frames them, and admits or drops whole frames
// into a FIFO drained as an AXI-stream master. Define PFB_PACK_DROP_CNT_EN to add the drop_cnt port.
module pfb_frame_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_data,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   pfb_data,
  input  logic                    pfb_valid,
  output logic [2*DATA_WIDTH-1:0] m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    frame_drop,
  output logic                    ovf_sticky
`ifdef PFB_PACK_DROP_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]    drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, ACCEPT, SKIP} state_t;

  state_t                  state;
  logic                    branch_b;
  logic [DATA_WIDTH-1:0]   hold_a;
  logic [WW-1:0]           widx;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic [2*DATA_WIDTH:0]   mem [FIFO_DEPTH];

  logic a_smp, b_smp, wlast, room, wr, rd;

  assign a_smp = pfb_valid && !branch_b;
  assign b_smp = pfb_valid &&  branch_b;
  assign wlast = (widx == WW'(FRAME_LEN-1));
  // Decision on registered count only; a same-cycle pop is not credited.
  assign room  = (count <= (AW+1)'(FIFO_DEPTH-FRAME_LEN));
  assign wr    = b_smp && (state == ACCEPT);
  assign rd    = m_tvalid && m_tready;

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      branch_b   <= 1'b0;
      hold_a     <= '0;
      widx       <= '0;
      frame_drop <= 1'b0;
      ovf_sticky <= 1'b0;
`ifdef PFB_PACK_DROP_CNT_EN
      drop_cnt   <= '0;
`endif
    end else begin
      frame_drop <= 1'b0;
      if (pfb_valid) branch_b <= ~branch_b;
      if (a_smp) begin
        hold_a <= pfb_data;
        if (widx == '0) begin
          if (room) begin
            state <= ACCEPT;
          end else begin
            state      <= SKIP;
            frame_drop <= 1'b1;
            ovf_sticky <= 1'b1;
`ifdef PFB_PACK_DROP_CNT_EN
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
`endif
          end
        end
      end
      // widx advances on every completed pair so frame boundaries track the input.
      if (b_smp) widx <= wlast ? '0 : widx + 1'b1;
    end
  end

  always_ff @(posedge clk_data) begin
    if (wr) mem[wr_ptr] <= {wlast, pfb_data, hold_a};
  end

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !rd)      count <= count + 1'b1;
      else if (!wr && rd) count <= count - 1'b1;
    end
  end

  // Head word gated to zero when empty so reset and idle outputs read as 0.
  assign m_tvalid = (count != '0);
  assign {m_tlast, m_tdata} = m_tvalid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_pfb_frame_packer.sv
// Directed bench for pfb_frame_packer: pairing, framing, drop, stall stability and mid-stream reset.
module tb_pfb_frame_packer;

  logic        clk_data = 1'b0;
  logic        rst_n;
  logic [15:0] pfb_data;
  logic        pfb_valid;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        frame_drop;
  logic        ovf_sticky;
`ifdef PFB_PACK_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  pfb_frame_packer dut (
    .clk_data   (clk_data),
    .rst_n      (rst_n),
    .pfb_data   (pfb_data),
    .pfb_valid  (pfb_valid),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .frame_drop (frame_drop),
    .ovf_sticky (ovf_sticky)
`ifdef PFB_PACK_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk_data = ~clk_data;

  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt = 0;
  logic [32:0] q [$];
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Capture accepted beats, count drop pulses, and check stall stability away from the clock edge.
  always @(negedge clk_data) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_data", 64'(m_tdata), 64'(prev_word[31:0]));
        chk("stall_last", 64'(m_tlast), 64'(prev_word[32]));
      end
      if (m_tvalid && m_tready) q.push_back({m_tlast, m_tdata});
      if (frame_drop) fd_cnt++;
      prev_stall = m_tvalid && !m_tready;
      prev_word  = {m_tlast, m_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [32:0] pw(input int a, input bit last);
    return {last, 16'(a + 1), 16'(a)};
  endfunction

  task automatic send(input int v);
    @(posedge clk_data); #1;
    pfb_valid = 1'b1;
    pfb_data  = 16'(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_data); #1;
      pfb_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk_data); #1;
    rst_n     = 1'b0;
    pfb_valid = 1'b0;
    repeat (2) @(posedge clk_data);
    #1 rst_n = 1'b1;
    q.delete();
    fd_cnt = 0;
  endtask

  task automatic drain(input int max);
    int i;
    i = 0;
    while (m_tvalid && i < max) begin
      @(posedge clk_data); #1;
      i++;
    end
    @(negedge clk_data);
    chk("drain_done", 64'(m_tvalid), 64'(0));
  endtask

  // Word k of a run whose first A sample is base: {k%16==15, base+2k+1, base+2k}
  task automatic chk_frame(input string tag, input int base, input int n);
    chk({tag, "_size"}, 64'(q.size()), 64'(n));
    for (int k = 0; k < n && k < q.size(); k++)
      chk(tag, 64'(q[k]), 64'(pw(base + 2*k, (k % 16) == 15)));
  endtask

  initial begin
    rst_n     = 1'b0;
    pfb_valid = 1'b0;
    pfb_data  = '0;
    m_tready  = 1'b1;
    repeat (3) @(posedge clk_data);
    @(negedge clk_data);
    chk("rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_tlast",  64'(m_tlast),  64'(0));
    chk("rst_tdata",  64'(m_tdata),  64'(0));
    chk("rst_drop",   64'(frame_drop), 64'(0));
    chk("rst_ovf",    64'(ovf_sticky), 64'(0));
`ifdef PFB_PACK_DROP_CNT_EN
    chk("rst_dcnt",   64'(drop_cnt), 64'(0));
`endif
    @(posedge clk_data); #1 rst_n = 1'b1;

    // Basic stream 1..32 with latency check after sample 2
    send(1);
    send(2);
    @(negedge clk_data);
    chk("lat_n", 64'(m_tvalid), 64'(0));
    send(3);
    @(negedge clk_data);
    chk("lat_n1", 64'(m_tvalid), 64'(1));
    chk("lat_word", 64'({m_tlast, m_tdata}), 64'(pw(1, 1'b0)));
    for (int v = 4; v <= 32; v++) send(v);
    idle(4);
    chk_frame("basic", 1, 16);
    chk("basic_drop", 64'(fd_cnt), 64'(0));

    // Gapped valid: 1 on, 2 off
    do_reset();
    for (int v = 1; v <= 8; v++) begin
      send(v);
      idle(2);
    end
    idle(3);
    chk_frame("gap", 1, 4);

    // Sign preservation
    do_reset();
    send(-5);
    send(-1);
    idle(3);
    chk("neg_size", 64'(q.size()), 64'(1));
    if (q.size() > 0) chk("neg_word", 64'(q[0]), 64'({1'b0, 16'hFFFF, 16'hFFFB}));

    // Overflow: 3 frames with no drain, third dropped
    do_reset();
    m_tready = 1'b0;
    for (int v = 1; v <= 96; v++) send(v);
    idle(3);
    @(negedge clk_data);
    chk("ovf_pulses", 64'(fd_cnt), 64'(1));
    chk("ovf_sticky", 64'(ovf_sticky), 64'(1));
    chk("ovf_tvalid", 64'(m_tvalid), 64'(1));
    chk("ovf_nopop",  64'(q.size()), 64'(0));
`ifdef PFB_PACK_DROP_CNT_EN
    chk("ovf_dcnt", 64'(drop_cnt), 64'(1));
`endif
    @(posedge clk_data); #1 m_tready = 1'b1;
    drain(100);
    chk_frame("ovf_drain", 1, 32);
    q.delete();
    for (int v = 97; v <= 128; v++) send(v);
    idle(4);
    chk_frame("frame4", 97, 16);
    chk("frame4_drop", 64'(fd_cnt), 64'(1));
    chk("frame4_ovf", 64'(ovf_sticky), 64'(1));

    // Toggling ready during output
    do_reset();
    m_tready = 1'b0;
    for (int v = 1; v <= 32; v++) send(v);
    idle(2);
    begin
      int i;
      i = 0;
      while (m_tvalid && i < 200) begin
        @(posedge clk_data); #1 m_tready = ~m_tready;
        i++;
      end
      chk("tog_timeout", 64'(i < 200), 64'(1));
    end
    @(negedge clk_data);
    chk("tog_empty", 64'(m_tvalid), 64'(0));
    chk_frame("tog", 1, 16);

    // Reset mid-frame and mid-output
    do_reset();
    m_tready = 1'b0;
    for (int v = 1; v <= 42; v++) send(v);
    idle(1);
    m_tready = 1'b1;
    repeat (3) @(posedge clk_data);
    #1 rst_n = 1'b0;
    @(negedge clk_data);
    chk("mrst_tvalid", 64'(m_tvalid), 64'(0));
    chk("mrst_tdata",  64'(m_tdata),  64'(0));
    @(posedge clk_data); #1 rst_n = 1'b1;
    q.delete();
    fd_cnt = 0;
    for (int v = 1; v <= 32; v++) send(v);
    idle(4);
    chk_frame("mrst", 1, 16);
    chk("mrst_ovf", 64'(ovf_sticky), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
